mac_grid: RTL and testbench
===========================

# mac_grid

Parametrised output-stationary systolic MAC grid of ROWS x COLS processing elements computing C = A x B (A is ROWS x k_len, B is k_len x COLS) over a run of k_len beats. Owns input skewing, a run sequencer (clear, feed, flush, drain), optional accumulator saturation and a valid/ready result port. It supersedes the fixed 2x2 MAC array, sits between the activation/weight buffers and the result writeback path, and has internal MAC processing elements.

## Interface
- W, 8: signed operand width.
- ACC_W, 16: signed accumulator width. Must be >= 2*W.
- ROWS, 2: grid rows, >= 1.
- COLS, 2: grid columns, >= 1.
- KW, 8: width of k_len.
- SAT, 1: 1 = saturating accumulate, 0 = two's-complement wrap.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled in IDLE only.
- k_len  in  KW  beats in the run; captured when start is accepted.
- busy  out  1  high from the start acceptance edge until done.
- a_valid  in  1  feed beat valid.
- a_ready  out  1  high in FEED only.
- a_data  in  ROWS*W  column k of A; lane i is bits [i*W +: W].
- b_data  in  COLS*W  row k of B; lane j is bits [j*W +: W]. Qualified by a_valid.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accepted.
- out_data  out  COLS*ACC_W  C row out_row; lane j is bits [j*ACC_W +: ACC_W].
- out_row  out  $clog2(ROWS) (min 1)  index of the presented row.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- The state machine has five states: IDLE, CLEAR, FEED, FLUSH and DRAIN.
- IDLE: when start=1, capture k_len, set busy and move to CLEAR. Any start outside IDLE is ignored.
- CLEAR: lasts 1 cycle. It zeroes all accumulators and skew/pipe registers. The next state is FEED if k_len>0, otherwise DRAIN.
- FEED:
  - a_ready=1. Each a_valid&&a_ready accepts one beat and advances the grid by one step (global enable).
  - When a_valid=0 the grid holds: there is no step and no accumulate.
  - After k_len accepted beats, move to FLUSH.
- Skew:
  - A lane i is delayed i steps before entering PE(i,0). B lane j is delayed j steps before entering PE(0,j).
  - A moves right and B moves down one PE per step.
  - PE(i,j) accumulates beat k at step k+i+j.
- FLUSH:
  - Lasts ROWS+COLS-2 cycles, with the grid stepping every cycle and zeros injected at the inputs.
  - If the count is zero, go straight to DRAIN.
- DRAIN:
  - Present rows 0..ROWS-1 in order: out_valid=1, out_row=r, out_data = accumulators of row r.
  - Advance r on out_valid&&out_ready.
  - After the handshake on row ROWS-1, return to IDLE, pulse done and drop busy.
- Arithmetic:
  - The product is a full signed 2W-bit value, sign-extended to ACC_W.
  - SAT=1: a sum above 2^(ACC_W-1)-1 clamps to that value; a sum below -2^(ACC_W-1) clamps to that value.
  - Saturation is sticky per element only through the clamped value; there is no flag.
  - SAT=0: the sum wraps modulo 2^ACC_W.
- k_len=0: the run goes CLEAR, then DRAIN, and outputs all-zero rows.
- Reset (at any time, including mid-run): immediately returns the block to IDLE. All outputs and internal state go to 0; no done pulse.

## Timing
- Reset values: busy=0, a_ready=0, out_valid=0, out_data=0, out_row=0, done=0.
- Start edge: CLEAR is the next cycle, and busy rises on the same edge that leaves IDLE.
- a_ready is registered state decode. It is high in the first FEED cycle and low in the cycle after the k_len-th acceptance.
- With no stalls, out_valid first rises k_len + (ROWS+COLS-2) + 2 cycles after the start edge. This counts CLEAR, FEED and FLUSH, with DRAIN entered on the following edge.
- out_data and out_row are stable while out_valid=1 and out_ready=0.
- A new row appears on the cycle after each handshake.
- done is high for exactly the cycle after the last row handshake, in which the block is in IDLE with busy=0.
- start in that same cycle is accepted (back-to-back runs allowed).

## Test plan
- ROWS=COLS=2, k_len=2; beats a_data {1,3},{2,4}; b_data {5,6},{7,8}; out_ready=1 -> row0 {19,22}, row1 {43,50}; done one cycle after row1 handshake.
- Same run with a_valid low for 3 cycles between beats -> identical results. a_ready stays high during the gap; first out_valid is delayed by exactly 3 cycles.
- W=8, ACC_W=16, k_len=3, all operands -128:
  - SAT=1 -> every element is 32767.
  - SAT=0 -> every element is -16384.
- Test 1 with out_ready low for 5 cycles at the start of DRAIN -> row0 {19,22} held stable with out_row=0; then rows in order; done timing as specified.
- Two start cases:
  - k_len=0 -> two rows of {0,0}, then done.
  - start pulsed during FEED -> ignored; the run completes unchanged.
- rst asserted mid-FEED after 1 beat -> all outputs 0 immediately. After release, a fresh test-1 run gives {19,22},{43,50} with no residue.

Source files
------------

// File: rtl/mac_grid.sv
// Output-stationary ROWS x COLS systolic MAC grid computing C = A x B over k_len beats,
// with input skewing, a clear/feed/flush/drain sequencer and a valid/ready row port.
module mac_grid #(
    parameter int W     = 8,
    parameter int ACC_W = 16,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int KW    = 8,
    parameter bit SAT   = 1'b1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [KW-1:0]          k_len_i,
    output logic                   busy_o,
    input  logic                   a_valid_i,
    output logic                   a_ready_o,
    input  logic [ROWS*W-1:0]      a_data_i,
    input  logic [COLS*W-1:0]      b_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [COLS*ACC_W-1:0]  out_data_o,
    output logic [RW-1:0]          out_row_o,
    output logic                   done_o
);

    localparam int FLUSH_N = ROWS + COLS - 2;
    localparam int FCW     = $clog2(ROWS + COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_len_q;
    logic [KW-1:0]    beat_q;
    logic [FCW-1:0]   flush_q;
    logic             busy_q;
    logic             a_ready_q;
    logic             out_valid_q;
    logic [RW-1:0]    out_row_q;
    logic             done_q;

    logic             step;
    logic             clr;

    logic signed [W-1:0]     a_in [ROWS][COLS];
    logic signed [W-1:0]     b_in [ROWS][COLS];
    logic signed [ACC_W-1:0] acc  [ROWS][COLS];

    // Sum is formed one bit wider so overflow shows up as a sign disagreement.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] acc_v,
        input logic signed [2*W-1:0]   prod_v
    );
        logic signed [ACC_W:0] sum;
        sum = (ACC_W+1)'(acc_v) + (ACC_W+1)'(prod_v);
        if (SAT && (sum[ACC_W] != sum[ACC_W-1])) begin
            acc_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_add = sum[ACC_W-1:0];
        end
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
            a_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_len_q <= k_len_i;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    beat_q  <= '0;
                    flush_q <= '0;
                    if (k_len_q != '0) begin
                        state_q   <= S_FEED;
                        a_ready_q <= 1'b1;
                    end else begin
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                    end
                end
                S_FEED: begin
                    if (a_valid_i) begin
                        beat_q <= beat_q + KW'(1);
                        if (beat_q == k_len_q - KW'(1)) begin
                            a_ready_q <= 1'b0;
                            if (FLUSH_N == 0) begin
                                state_q     <= S_DRAIN;
                                out_valid_q <= 1'b1;
                                out_row_q   <= '0;
                            end else begin
                                state_q <= S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    flush_q <= flush_q + FCW'(1);
                    if (flush_q == FCW'(FLUSH_N - 1)) begin
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        if (out_row_q == RW'(ROWS - 1)) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_row_q   <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_row_q <= out_row_q + RW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign step = ((state_q == S_FEED) && a_valid_i) || (state_q == S_FLUSH);
    assign clr  = (state_q == S_CLEAR);

    // A lane i reaches column 0 after i grid steps; zeros enter outside FEED.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic signed [W-1:0] a_edge;
        assign a_edge = (state_q == S_FEED) ? a_data_i[i*W +: W] : '0;
        if (i == 0) begin : g_direct
            assign a_in[i][0] = a_edge;
        end else begin : g_delay
            logic signed [W-1:0] sr_q [i];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else if (clr) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else if (step) begin
                    sr_q[0] <= a_edge;
                    for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign a_in[i][0] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic signed [W-1:0] b_edge;
        assign b_edge = (state_q == S_FEED) ? b_data_i[j*W +: W] : '0;
        if (j == 0) begin : g_direct
            assign b_in[0][j] = b_edge;
        end else begin : g_delay
            logic signed [W-1:0] sr_q [j];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int s = 0; s < j; s++) sr_q[s] <= '0;
                end else if (clr) begin
                    for (int s = 0; s < j; s++) sr_q[s] <= '0;
                end else if (step) begin
                    sr_q[0] <= b_edge;
                    for (int s = 1; s < j; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign b_in[0][j] = sr_q[j-1];
        end
    end

    // Each PE accumulates in place and forwards A right and B down one step later.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic signed [ACC_W-1:0] acc_q;
            logic signed [ACC_W-1:0] acc_d;
            logic signed [2*W-1:0]   prod;

            assign prod = a_in[i][j] * b_in[i][j];

            always_comb begin
                acc_d = acc_q;
                if (clr) begin
                    acc_d = '0;
                end else if (step) begin
                    acc_d = acc_add(acc_q, prod);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign acc[i][j] = acc_q;

            if (j < COLS - 1) begin : g_fwd_a
                logic signed [W-1:0] a_q;
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        a_q <= '0;
                    end else if (clr) begin
                        a_q <= '0;
                    end else if (step) begin
                        a_q <= a_in[i][j];
                    end
                end
                assign a_in[i][j+1] = a_q;
            end

            if (i < ROWS - 1) begin : g_fwd_b
                logic signed [W-1:0] b_q;
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        b_q <= '0;
                    end else if (clr) begin
                        b_q <= '0;
                    end else if (step) begin
                        b_q <= b_in[i][j];
                    end
                end
                assign b_in[i+1][j] = b_q;
            end
        end
    end

    always_comb begin
        out_data_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (out_valid_q && (out_row_q == RW'(r))) begin
                for (int c = 0; c < COLS; c++) begin
                    out_data_o[c*ACC_W +: ACC_W] = acc[r][c];
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign a_ready_o   = a_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_row_o   = out_row_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mac_grid.sv
// Bench for mac_grid: directed and random runs against a plain matrix-product model,
// with a saturating and a wrapping instance driven in parallel.
module tb_mac_grid;

    localparam int W       = 8;
    localparam int ACC_W   = 16;
    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int KW      = 8;
    localparam int RW      = 1;
    localparam int F       = ROWS + COLS - 2;
    localparam int MAXK    = 16;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  start_i;
    logic [KW-1:0]         k_len_i;
    logic                  a_valid_i;
    logic [ROWS*W-1:0]     a_data_i;
    logic [COLS*W-1:0]     b_data_i;
    logic                  out_ready_i;

    logic                  busy_s, a_ready_s, out_valid_s, done_s;
    logic [COLS*ACC_W-1:0] out_data_s;
    logic [RW-1:0]         out_row_s;
    logic                  busy_w, a_ready_w, out_valid_w, done_w;
    logic [COLS*ACC_W-1:0] out_data_w;
    logic [RW-1:0]         out_row_w;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int a_m   [ROWS][MAXK];
    int b_m   [MAXK][COLS];
    int exp_s [ROWS][COLS];
    int exp_w [ROWS][COLS];

    mac_grid #(.W(W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .KW(KW), .SAT(1'b1)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i), .busy_o(busy_s),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_s), .a_data_i(a_data_i), .b_data_i(b_data_i),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_i), .out_data_o(out_data_s),
        .out_row_o(out_row_s), .done_o(done_s)
    );

    mac_grid #(.W(W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .KW(KW), .SAT(1'b0)) dut_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i), .busy_o(busy_w),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_w), .a_data_i(a_data_i), .b_data_i(b_data_i),
        .out_valid_o(out_valid_w), .out_ready_i(out_ready_i), .out_data_o(out_data_w),
        .out_row_o(out_row_w), .done_o(done_w)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // C = A x B, accumulated in k order; clamping after every add gives sticky saturation.
    task automatic compute(input int k);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                int s;
                int w;
                s = 0;
                w = 0;
                for (int kk = 0; kk < k; kk++) begin
                    s = s + a_m[i][kk] * b_m[kk][j];
                    if (s > ACC_MAX) s = ACC_MAX;
                    if (s < ACC_MIN) s = ACC_MIN;
                    w = w + a_m[i][kk] * b_m[kk][j];
                end
                w = w & ((1 << ACC_W) - 1);
                if (w > ACC_MAX) w = w - (1 << ACC_W);
                exp_s[i][j] = s;
                exp_w[i][j] = w;
            end
        end
    endtask

    task automatic load_t1();
        a_m[0][0] = 1; a_m[1][0] = 3; a_m[0][1] = 2; a_m[1][1] = 4;
        b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < ROWS; i++) a_data_i[i*W +: W] = a_m[i][kk][W-1:0];
        for (int j = 0; j < COLS; j++) b_data_i[j*W +: W] = b_m[kk][j][W-1:0];
    endtask

    function automatic int rand_op();
        case ($urandom_range(3))
            0:       return -128;
            1:       return 127;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    task automatic check_row(input int r);
        check_val("row_valid", out_valid_s, 1);
        check_val("row_index", out_row_s, r);
        check_val("row_index_w", out_row_w, r);
        for (int j = 0; j < COLS; j++) begin
            check_val($sformatf("sat_r%0d_c%0d", r, j), $signed(out_data_s[j*ACC_W +: ACC_W]), exp_s[r][j]);
            check_val($sformatf("wrap_r%0d_c%0d", r, j), $signed(out_data_w[j*ACC_W +: ACC_W]), exp_w[r][j]);
        end
    endtask

    // Starts in the current cycle; returns in the done cycle so the next run can start there.
    task automatic run(input int k, input int gap, input bit rnd, input int stall0,
                       input bit rnd_ready, input bit poke_start);
        int t0, beat, idle, budget, gap_left, lat;
        compute(k);
        out_ready_i = 1'b0;
        start_i     = 1'b1;
        k_len_i     = KW'(k);
        t0          = cyc;
        tick();
        start_i = 1'b0;
        check_val("busy_rise", busy_s, 1);
        check_val("ready_clear", a_ready_s, 0);
        check_val("done_clear", done_s, 0);
        idle = 0;
        if (k > 0) begin
            tick();
            beat = 0;
            budget = 0;
            gap_left = gap;
            while (beat < k && budget < 1000) begin
                bit v;
                v = 1'b1;
                if (beat == 1 && gap_left > 0) begin
                    v = 1'b0;
                    gap_left--;
                end else if (rnd && $urandom_range(3) == 0) begin
                    v = 1'b0;
                end
                check_val("a_ready_feed", a_ready_s, 1);
                a_valid_i = v;
                if (v) drive_beat(beat);
                else begin
                    a_data_i = (ROWS*W)'($urandom);
                    b_data_i = (COLS*W)'($urandom);
                end
                if (poke_start && beat == 0) begin
                    start_i = 1'b1;
                    k_len_i = KW'(5);
                end
                tick();
                start_i = 1'b0;
                if (v) beat++;
                else idle++;
                budget++;
            end
            a_valid_i = 1'b0;
            check_val("feed_beats", beat, k);
            check_val("a_ready_off", a_ready_s, 0);
        end
        budget = 0;
        while (!out_valid_s && budget < 200) begin
            tick();
            budget++;
        end
        check_val("out_valid_rise", out_valid_s, 1);
        lat = cyc - t0;
        check_val("latency", lat, (k == 0) ? 2 : k + F + 2 + idle);
        for (int r = 0; r < ROWS; r++) begin
            int st;
            st = (r == 0) ? stall0 : 0;
            if (rnd_ready) st += $urandom_range(2);
            for (int s = 0; s <= st; s++) begin
                out_ready_i = (s == st);
                check_row(r);
                check_val("busy_drain", busy_s, 1);
                tick();
            end
        end
        out_ready_i = 1'b0;
        check_val("done_pulse", done_s, 1);
        check_val("done_pulse_w", done_w, 1);
        check_val("busy_fall", busy_s, 0);
        check_val("busy_fall_w", busy_w, 0);
        check_val("valid_fall", out_valid_s, 0);
        check_val("valid_fall_w", out_valid_w, 0);
        check_val("data_idle", out_data_s, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, busy_s, 0);
        check_val({tag, "_a_ready"}, a_ready_s, 0);
        check_val({tag, "_a_ready_w"}, a_ready_w, 0);
        check_val({tag, "_out_valid"}, out_valid_s, 0);
        check_val({tag, "_out_data"}, out_data_s, 0);
        check_val({tag, "_out_data_w"}, out_data_w, 0);
        check_val({tag, "_out_row"}, out_row_s, 0);
        check_val({tag, "_done"}, done_s, 0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        k_len_i     = '0;
        a_valid_i   = 1'b0;
        a_data_i    = '0;
        b_data_i    = '0;
        out_ready_i = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        tick();

        load_t1();
        run(2, 0, 1'b0, 0, 1'b0, 1'b0);
        run(2, 3, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < 3; kk++) a_m[i][kk] = -128;
        for (int kk = 0; kk < 3; kk++) for (int j = 0; j < COLS; j++) b_m[kk][j] = -128;
        run(3, 0, 1'b0, 0, 1'b0, 1'b0);

        load_t1();
        run(2, 0, 1'b0, 5, 1'b0, 1'b0);
        run(0, 0, 1'b0, 0, 1'b0, 1'b0);
        run(2, 0, 1'b0, 0, 1'b0, 1'b1);

        start_i = 1'b1;
        k_len_i = KW'(2);
        tick();
        start_i = 1'b0;
        tick();
        a_valid_i = 1'b1;
        drive_beat(0);
        tick();
        a_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check_reset_outputs("after_release");
        run(2, 0, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int k;
            k = $urandom_range(8);
            for (int i = 0; i < ROWS; i++) for (int kk = 0; kk < k; kk++) a_m[i][kk] = rand_op();
            for (int kk = 0; kk < k; kk++) for (int j = 0; j < COLS; j++) b_m[kk][j] = rand_op();
            run(k, 0, 1'b1, 0, 1'b1, 1'b0);
        end

        tick();
        check_val("done_single_cycle", done_s, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
